// File: rtl/bconv_window_if.sv
// Stream interface between a pixel source, the 3x3 window generator and the
// XNOR/popcount convolver that consumes the windows.
interface bconv_window_if #(
  parameter int INPUT_H = 28,
  parameter int INPUT_W = 28
) ();
  localparam int ROW_W = (INPUT_H > 3) ? $clog2(INPUT_H - 2) : 1;
  localparam int COL_W = (INPUT_W > 3) ? $clog2(INPUT_W - 2) : 1;

  logic             clear_i;
  logic             pix_i;
  logic             pix_valid_i;
  logic             pix_ready_o;
  logic [8:0]       win_o;
  logic [ROW_W-1:0] win_row_o;
  logic [COL_W-1:0] win_col_o;
  logic             win_valid_o;
  logic             win_ready_i;
  logic             frame_done_o;

  // Upstream pixel source / downstream consumer side.
  modport master (
    output clear_i, pix_i, pix_valid_i, win_ready_i,
    input  pix_ready_o, win_o, win_row_o, win_col_o, win_valid_o, frame_done_o
  );

  // Window generator side.
  modport slave (
    input  clear_i, pix_i, pix_valid_i, win_ready_i,
    output pix_ready_o, win_o, win_row_o, win_col_o, win_valid_o, frame_done_o
  );
endinterface

// File: rtl/bconv_window_gen.sv
// 3x3 sliding-window generator for a binarized image streamed in row-major
// order. Two line buffers hold rows r-1 and r-2; two column registers hold
// the previous two window columns, so each accepted pixel with r>=2, c>=2
// yields one window into a single-entry output register.
module bconv_window_gen #(
  parameter int INPUT_H = 28,
  parameter int INPUT_W = 28
) (
  input  logic          clk,
  input  logic          rst,
  bconv_window_if.slave bus
);
  localparam int RW    = $clog2(INPUT_H);
  localparam int CW    = $clog2(INPUT_W);
  localparam int ROW_W = (INPUT_H > 3) ? $clog2(INPUT_H - 2) : 1;
  localparam int COL_W = (INPUT_W > 3) ? $clog2(INPUT_W - 2) : 1;

  localparam logic [RW-1:0] R_LAST = RW'(INPUT_H - 1);
  localparam logic [CW-1:0] C_LAST = CW'(INPUT_W - 1);
  localparam logic [RW-1:0] R_ONE  = RW'(1);
  localparam logic [RW-1:0] R_TWO  = RW'(2);
  localparam logic [CW-1:0] C_TWO  = CW'(2);

  localparam logic [1:0] FILL   = 2'd0;
  localparam logic [1:0] STREAM = 2'd1;
  localparam logic [1:0] DRAIN  = 2'd2;

  logic [1:0]         state_reg, state_next;
  logic [RW-1:0]      r_reg;
  logic [CW-1:0]      c_reg;
  logic [INPUT_W-1:0] lb1_reg;      // row r-1, indexed by column
  logic [INPUT_W-1:0] lb2_reg;      // row r-2, indexed by column
  logic [2:0]         col1_reg;     // column c-1 as {top, mid, bottom}
  logic [2:0]         col2_reg;     // column c-2 as {top, mid, bottom}
  logic [8:0]         win_reg;
  logic [ROW_W-1:0]   row_reg;
  logic [COL_W-1:0]   col_reg;
  logic               valid_reg;

  logic       pix_ready;
  logic       pix_accept;
  logic       win_consume;
  logic       frame_done;
  logic       row_end;
  logic       win_hit;
  logic [2:0] cur_col;
  logic [8:0] win_next;

  // Ready is forced low during reset and clear so no pixel slips in.
  assign pix_ready = !rst && !bus.clear_i &&
                     ((state_reg == FILL) ||
                      ((state_reg == STREAM) && (!valid_reg || bus.win_ready_i)));

  assign pix_accept  = bus.pix_valid_i && pix_ready;
  assign win_consume = valid_reg && bus.win_ready_i;
  assign frame_done  = (state_reg == DRAIN) && win_consume && !bus.clear_i;
  assign row_end     = (c_reg == C_LAST);
  assign win_hit     = pix_accept && (r_reg >= R_TWO) && (c_reg >= C_TWO);

  // Column entering the window: rows r-2, r-1 from the buffers, row r live.
  assign cur_col = {lb2_reg[c_reg], lb1_reg[c_reg], bus.pix_i};

  // Window row gi (2 = top) packed as {c-2, c-1, c}, top row in the MSBs.
  for (genvar gi = 0; gi < 3; gi++) begin : g_win_row
    assign win_next[3*gi +: 3] = {col2_reg[gi], col1_reg[gi], cur_col[gi]};
  end

  assign bus.pix_ready_o  = pix_ready;
  assign bus.win_o        = win_reg;
  assign bus.win_row_o    = row_reg;
  assign bus.win_col_o    = col_reg;
  assign bus.win_valid_o  = valid_reg;
  assign bus.frame_done_o = frame_done;

  // Frame phase: fill the first two rows, stream windows, then drain the last.
  always_comb begin
    state_next = state_reg;
    case (state_reg)
      FILL:    if (pix_accept && (r_reg == R_ONE) && row_end)  state_next = STREAM;
      STREAM:  if (pix_accept && (r_reg == R_LAST) && row_end) state_next = DRAIN;
      DRAIN:   if (frame_done)                                 state_next = FILL;
      default: state_next = FILL;
    endcase
  end

  // State register; a clear aborts the frame from any state.
  always_ff @(posedge clk or posedge rst) begin
    if (rst)              state_reg <= FILL;
    else if (bus.clear_i) state_reg <= FILL;
    else                  state_reg <= state_next;
  end

  // Raster position of the next pixel; wraps to (0,0) after the last one.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_reg <= '0;
      c_reg <= '0;
    end else if (bus.clear_i) begin
      r_reg <= '0;
      c_reg <= '0;
    end else if (pix_accept) begin
      if (row_end) begin
        c_reg <= '0;
        r_reg <= (r_reg == R_LAST) ? '0 : r_reg + R_ONE;
      end else begin
        c_reg <= c_reg + CW'(1);
      end
    end
  end

  // Line buffers shift down one row per column; window columns shift left.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      lb1_reg  <= '0;
      lb2_reg  <= '0;
      col1_reg <= '0;
      col2_reg <= '0;
    end else if (bus.clear_i) begin
      lb1_reg  <= '0;
      lb2_reg  <= '0;
      col1_reg <= '0;
      col2_reg <= '0;
    end else if (pix_accept) begin
      lb2_reg[c_reg] <= lb1_reg[c_reg];
      lb1_reg[c_reg] <= bus.pix_i;
      col2_reg       <= col1_reg;
      col1_reg       <= cur_col;
    end
  end

  // Single output stage: load on a producing pixel, hold under backpressure.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      win_reg   <= '0;
      row_reg   <= '0;
      col_reg   <= '0;
      valid_reg <= 1'b0;
    end else if (bus.clear_i) begin
      valid_reg <= 1'b0;
    end else if (win_hit) begin
      win_reg   <= win_next;
      row_reg   <= ROW_W'(r_reg - R_TWO);
      col_reg   <= COL_W'(c_reg - C_TWO);
      valid_reg <= 1'b1;
    end else if (win_consume) begin
      valid_reg <= 1'b0;
    end
  end
endmodule

// File: tb/tb_bconv_window_gen.sv
// Randomized bench for bconv_window_gen. The reference keeps the received
// image in a 2D array and builds each expected window straight from the
// pixel-to-bit mapping; a negedge monitor compares every cycle.
module tb_bconv_window_gen;
  localparam int H  = 28;
  localparam int W  = 28;
  localparam int OH = H - 2;
  localparam int OW = W - 2;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  bconv_window_if #(.INPUT_H(H), .INPUT_W(W)) bus ();

  bconv_window_gen #(.INPUT_H(H), .INPUT_W(W)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  typedef struct {
    logic [8:0] w;
    int         row;
    int         col;
  } win_t;

  win_t exp_q[$];
  logic img [H][W];
  int   mr, mc;
  bit   drain;
  int   n_cmp = 0;
  int   n_bad = 0;
  int   cyc   = 0;

  // Stimulus configuration.
  bit drv_en = 0;
  int cfg_mode = 4, cfg_vprob = 100, cfg_rprob = 100;
  bit bp_en = 0, clear_pending = 0;
  int bp_left = 0;

  // Per-phase statistics.
  int         win_cnt, fd_cnt, nz_cnt, pat_bad, stall_cnt, stall_rdy0;
  int         first_row, first_col, first_cyc, acc22_cyc;
  bit         first_seen;
  logic [8:0] first_w;
  logic [8:0] got [OH][OW];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Pixel value for image position (r,c) under each stimulus mode.
  function automatic logic pattern(input int mode, input int r, input int c);
    case (mode)
      0:       return ((r + c) % 2) == 1;
      1:       return 1'b1;
      2:       return (r == 10) && (c == 10);
      3:       return $urandom_range(1) == 1;
      default: return 1'b0;
    endcase
  endfunction

  // Expected window whose bottom-right pixel is (r,c).
  function automatic logic [8:0] model_win(input int r, input int c);
    logic [8:0] w;
    w = '0;
    for (int i = 0; i < 3; i++)
      for (int j = 0; j < 3; j++)
        w[3*(2-i) + (2-j)] = img[r-2+i][c-2+j];
    return w;
  endfunction

  task automatic reset_stats();
    win_cnt = 0; fd_cnt = 0; nz_cnt = 0; pat_bad = 0;
    stall_cnt = 0; stall_rdy0 = 0; first_seen = 0;
    for (int r = 0; r < OH; r++)
      for (int c = 0; c < OW; c++)
        got[r][c] = '0;
  endtask

  task automatic start_phase(input int mode, input int vp, input int rp);
    cfg_mode = mode; cfg_vprob = vp; cfg_rprob = rp;
    reset_stats();
    drv_en = 1;
  endtask

  task automatic wait_frames(input int n, input int budget);
    int k;
    k = 0;
    while (fd_cnt < n && k < budget) begin
      @(posedge clk);
      k++;
    end
    drv_en = 0;
    chk("frame_timeout", 32'(fd_cnt >= n), 32'd1);
    repeat (4) @(posedge clk);
  endtask

  // Driver: inputs change 1 time unit after each rising edge.
  initial begin
    bus.pix_valid_i = 1'b0;
    bus.pix_i       = 1'b0;
    bus.clear_i     = 1'b0;
    bus.win_ready_i = 1'b1;
    forever begin
      @(posedge clk);
      #1;
      bus.clear_i = 1'b0;
      if (!drv_en) begin
        bus.pix_valid_i = 1'b0;
        bus.win_ready_i = 1'b1;
      end else begin
        bus.pix_valid_i = ($urandom_range(99) < cfg_vprob);
        bus.pix_i       = pattern(cfg_mode, mr, mc);
        if (clear_pending && mr == 15 && mc == 3) begin
          bus.clear_i   = 1'b1;
          clear_pending = 0;
        end
        if (bp_en && bp_left > 0 && bus.win_valid_o &&
            bus.win_row_o == 3 && bus.win_col_o == 7) begin
          bus.win_ready_i = 1'b0;
          bp_left--;
        end else begin
          bus.win_ready_i = ($urandom_range(99) < cfg_rprob);
        end
      end
    end
  end

  // Monitor and reference model, sampled on the falling edge.
  logic       exp_ready, fd_exp, hold_prev;
  logic [8:0] prev_w;
  logic [4:0] prev_row, prev_col;
  win_t       e, pe;

  initial begin
    hold_prev = 0; mr = 0; mc = 0; drain = 0;
    forever begin
      @(negedge clk);
      cyc++;
      if (rst) begin
        chk("rst_win",        32'(bus.win_o),        32'd0);
        chk("rst_row",        32'(bus.win_row_o),    32'd0);
        chk("rst_col",        32'(bus.win_col_o),    32'd0);
        chk("rst_valid",      32'(bus.win_valid_o),  32'd0);
        chk("rst_frame_done", 32'(bus.frame_done_o), 32'd0);
        chk("rst_pix_ready",  32'(bus.pix_ready_o),  32'd0);
        exp_q.delete();
        mr = 0; mc = 0; drain = 0; hold_prev = 0;
      end else begin
        exp_ready = !bus.clear_i && !drain && (exp_q.size() == 0 || bus.win_ready_i);
        chk("pix_ready", 32'(bus.pix_ready_o), 32'(exp_ready));
        chk("win_valid", 32'(bus.win_valid_o), 32'(exp_q.size() != 0));
        if (hold_prev) begin
          chk("hold_win", 32'(bus.win_o),     32'(prev_w));
          chk("hold_row", 32'(bus.win_row_o), 32'(prev_row));
          chk("hold_col", 32'(bus.win_col_o), 32'(prev_col));
        end
        fd_exp = 0;
        if (bus.win_valid_o && bus.win_ready_i && exp_q.size() != 0) begin
          e = exp_q.pop_front();
          chk("win",     32'(bus.win_o),     32'(e.w));
          chk("win_row", 32'(bus.win_row_o), 32'(e.row));
          chk("win_col", 32'(bus.win_col_o), 32'(e.col));
          win_cnt++;
          if (bus.win_o != 9'd0) nz_cnt++;
          if (bus.win_o != 9'h155 && bus.win_o != 9'h0AA) pat_bad++;
          got[e.row][e.col] = bus.win_o;
          if (!bus.clear_i && e.row == OH-1 && e.col == OW-1) fd_exp = 1;
        end
        chk("frame_done", 32'(bus.frame_done_o), 32'(fd_exp));
        if (bus.frame_done_o) fd_cnt++;
        if (fd_exp) begin
          drain = 0;
          $display("frame complete at cycle %0d: %0d windows in this phase", cyc, win_cnt);
        end
        if (bus.win_valid_o && !bus.win_ready_i && bus.win_row_o == 3 && bus.win_col_o == 7) begin
          stall_cnt++;
          if (!bus.pix_ready_o) stall_rdy0++;
        end
        if (!first_seen && bus.win_valid_o) begin
          first_seen = 1;
          first_w    = bus.win_o;
          first_row  = int'(bus.win_row_o);
          first_col  = int'(bus.win_col_o);
          first_cyc  = cyc;
        end
        if (bus.clear_i) begin
          exp_q.delete();
          mr = 0; mc = 0; drain = 0;
        end else if (bus.pix_valid_i && exp_ready) begin
          img[mr][mc] = bus.pix_i;
          if (mr == 2 && mc == 2) acc22_cyc = cyc;
          if (mr >= 2 && mc >= 2) begin
            pe.w   = model_win(mr, mc);
            pe.row = mr - 2;
            pe.col = mc - 2;
            exp_q.push_back(pe);
          end
          if (mr == H-1 && mc == W-1) drain = 1;
          mc++;
          if (mc == W) begin
            mc = 0;
            mr++;
            if (mr == H) mr = 0;
          end
        end
        hold_prev = bus.win_valid_o && !bus.win_ready_i && !bus.clear_i;
        prev_w    = bus.win_o;
        prev_row  = bus.win_row_o;
        prev_col  = bus.win_col_o;
      end
    end
  end

  initial begin
    int k;
    // Reset behaviour.
    repeat (2) @(negedge clk);
    chk("reset_valid", 32'(bus.win_valid_o), 32'd0);
    chk("reset_ready", 32'(bus.pix_ready_o), 32'd0);
    @(posedge clk); #3;
    rst = 1'b0;
    @(negedge clk);
    chk("ready_after_reset", 32'(bus.pix_ready_o), 32'd1);

    // Checkerboard, constant valid/ready.
    start_phase(0, 100, 100);
    wait_frames(1, 5000);
    chk("checker_windows", 32'(win_cnt), 32'd676);
    chk("checker_frames",  32'(fd_cnt),  32'd1);
    chk("checker_pattern", 32'(pat_bad), 32'd0);
    chk("checker_w00",     32'(got[0][0]), 32'h0AA);
    chk("checker_w01",     32'(got[0][1]), 32'h155);

    // All ones: first window latency and content.
    start_phase(1, 100, 100);
    wait_frames(1, 5000);
    chk("ones_first_win", 32'(first_w),   32'h1FF);
    chk("ones_first_row", 32'(first_row), 32'd0);
    chk("ones_first_col", 32'(first_col), 32'd0);
    chk("ones_latency",   32'(first_cyc - acc22_cyc), 32'd1);
    chk("ones_windows",   32'(win_cnt),   32'd676);

    // Backpressure at window (3,7).
    bp_en = 1; bp_left = 5;
    start_phase(3, 100, 100);
    wait_frames(1, 5000);
    bp_en = 0;
    chk("bp_stall_cycles", 32'(stall_cnt),  32'd5);
    chk("bp_ready_low",    32'(stall_rdy0), 32'd5);
    chk("bp_windows",      32'(win_cnt),    32'd676);

    // Single hot pixel at (10,10).
    start_phase(2, 100, 100);
    wait_frames(1, 5000);
    chk("hot_w88",     32'(got[8][8]),   32'h001);
    chk("hot_w99",     32'(got[9][9]),   32'h010);
    chk("hot_w1010",   32'(got[10][10]), 32'h100);
    chk("hot_nonzero", 32'(nz_cnt),      32'd9);

    // Clear at pixel (15,3), then a full frame.
    clear_pending = 1;
    start_phase(3, 90, 80);
    k = 0;
    while (clear_pending && k < 5000) begin @(posedge clk); k++; end
    chk("clear_issued", 32'(clear_pending), 32'd0);
    reset_stats();
    wait_frames(1, 8000);
    chk("clear_windows", 32'(win_cnt), 32'd676);
    chk("clear_frames",  32'(fd_cnt),  32'd1);

    // Reset mid-frame, then two back-to-back all-zero frames.
    start_phase(3, 80, 70);
    k = 0;
    while (mr != 12 && k < 5000) begin @(posedge clk); k++; end
    chk("mid_frame_reached", 32'(mr), 32'd12);
    @(posedge clk); #3;
    rst = 1'b1;
    cfg_mode = 4;
    repeat (3) @(posedge clk);
    #3;
    rst = 1'b0;
    reset_stats();
    wait_frames(2, 12000);
    chk("rst_frames_windows", 32'(win_cnt), 32'd1352);
    chk("rst_frames_done",    32'(fd_cnt),  32'd2);
    chk("rst_frames_nonzero", 32'(nz_cnt),  32'd0);

    // Random data with random valid/ready.
    start_phase(3, 60, 60);
    wait_frames(1, 12000);
    chk("random_windows", 32'(win_cnt), 32'd676);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
